// File: rtl/search_table_cmd_queue.sv
// search_table_cmd_queue
//
// Command sequencer placed in front of the binary search table. Lookup and
// maintenance commands are buffered in a circular FIFO, issued one at a time
// on the table's req/opReq strobes, given a fixed per-class latency, and
// answered with exactly one registered response each. The table never sees
// req and opReq in the same cycle.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid and its payload until that edge.
// Ready never depends on valid. cmd_ready is decoded from the registered
// occupancy only. rsp_valid and the rsp_* fields stay constant until
// rsp_ready is seen.
//
// Optional feature macro: SEARCH_CMDQ_STATS_EN adds the saturating
// statistics outputs stat_lookups, stat_hits and stat_errs.
//
// Ports
//   clk, reset             clock (rising edge); asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake
//   cmd_isOp               0 lookup, 1 maintenance op
//   cmd_opCode             00 add, 01 delete, 10 update, 11 clear
//   cmd_key, cmd_data      48-bit search key, 16-bit op payload
//   rsp_valid / rsp_ready  response handshake
//   rsp_isOp, rsp_found, rsp_err, rsp_result   response fields
//   tbl_req, tbl_opReq     one-cycle request strobes to the table
//   tbl_search, tbl_opSearch, tbl_opCode, tbl_opResult   table command fields
//   tbl_rdy, tbl_opRdy, tbl_found, tbl_opErr, tbl_result  table status/results
//   fifo_count             current FIFO occupancy
//   stat_*                 (SEARCH_CMDQ_STATS_EN only) saturating counters
//   fsm_state              sequencer state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP
module search_table_cmd_queue #(
    parameter int DEPTH      = 8,
    parameter int LOOKUP_LAT = 2,
    parameter int OP_LAT     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_isOp,
    input  logic [1:0]                cmd_opCode,
    input  logic [47:0]               cmd_key,
    input  logic [15:0]               cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_isOp,
    output logic                      rsp_found,
    output logic                      rsp_err,
    output logic [15:0]               rsp_result,
    output logic                      tbl_req,
    output logic                      tbl_opReq,
    output logic [47:0]               tbl_search,
    output logic [47:0]               tbl_opSearch,
    output logic [1:0]                tbl_opCode,
    output logic [15:0]               tbl_opResult,
    input  logic                      tbl_rdy,
    input  logic                      tbl_opRdy,
    input  logic                      tbl_found,
    input  logic                      tbl_opErr,
    input  logic [15:0]               tbl_result,
    output logic [$clog2(DEPTH):0]    fifo_count,
`ifdef SEARCH_CMDQ_STATS_EN
    output logic [15:0]               stat_lookups,
    output logic [15:0]               stat_hits,
    output logic [15:0]               stat_errs,
`endif
    output logic [1:0]                fsm_state
);

    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int MAXLAT = (LOOKUP_LAT > OP_LAT) ? LOOKUP_LAT : OP_LAT;
    localparam int WW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
    localparam int EW     = 67;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_n;

    // FIFO storage and bookkeeping
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    // Issue register: the command currently owned by the sequencer
    logic          iss_isOp;
    logic [1:0]    iss_opCode;
    logic [47:0]   iss_key;
    logic [15:0]   iss_data;

    logic [WW-1:0] wcnt;
    logic          capture;

    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    // A pop is the IDLE->ISSUE edge and nothing else.
    assign pop        = (state == S_IDLE) && (count != '0) && !rsp_valid
                        && tbl_rdy && tbl_opRdy;
    assign capture    = (state == S_WAIT) && (wcnt == '0);
    assign fifo_count = count;
    assign fsm_state  = state;

    // Strobes decode straight from the state register so that an asserted
    // reset removes them without waiting for a clock edge.
    assign tbl_req      = (state == S_ISSUE) && !iss_isOp;
    assign tbl_opReq    = (state == S_ISSUE) && iss_isOp;
    assign rsp_valid    = (state == S_RESP);
    assign tbl_search   = iss_key;
    assign tbl_opSearch = iss_key;
    assign tbl_opCode   = iss_opCode;
    assign tbl_opResult = iss_data;

    // Entry storage carries no reset: only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_isOp, cmd_opCode, cmd_key, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (pop) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (wcnt == '0) state_n = S_RESP;
            S_RESP:  if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_isOp   <= 1'b0;
            iss_opCode <= 2'b00;
            iss_key    <= '0;
            iss_data   <= '0;
            wcnt       <= '0;
            rsp_isOp   <= 1'b0;
            rsp_found  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (pop) begin
                {iss_isOp, iss_opCode, iss_key, iss_data} <= mem[rd_ptr];
            end
            // WAIT lasts exactly LAT cycles: load LAT-1 and leave at zero.
            if (state == S_ISSUE) begin
                wcnt <= iss_isOp ? WW'(OP_LAT - 1) : WW'(LOOKUP_LAT - 1);
            end else if (state == S_WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (capture) begin
                rsp_isOp <= iss_isOp;
                if (iss_isOp) begin
                    rsp_found  <= 1'b0;
                    rsp_err    <= tbl_opErr;
                    rsp_result <= '0;
                end else begin
                    rsp_found  <= tbl_found;
                    rsp_err    <= 1'b0;
                    rsp_result <= tbl_found ? tbl_result : 16'h0000;
                end
            end
        end
    end

`ifdef SEARCH_CMDQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_errs    <= '0;
        end else if (capture) begin
            if (!iss_isOp && stat_lookups != 16'hFFFF)
                stat_lookups <= stat_lookups + 1'b1;
            if (!iss_isOp && tbl_found && stat_hits != 16'hFFFF)
                stat_hits <= stat_hits + 1'b1;
            if (iss_isOp && tbl_opErr && stat_errs != 16'hFFFF)
                stat_errs <= stat_errs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_search_table_cmd_queue.sv
// Directed bench for search_table_cmd_queue with a small behavioural table
// model and an expected-response queue.
module tb_search_table_cmd_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_isOp;
    logic [1:0]  cmd_opCode;
    logic [47:0] cmd_key;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_isOp, rsp_found, rsp_err;
    logic [15:0] rsp_result;
    logic        tbl_req, tbl_opReq;
    logic [47:0] tbl_search, tbl_opSearch;
    logic [1:0]  tbl_opCode;
    logic [15:0] tbl_opResult;
    logic        tbl_rdy, tbl_opRdy, tbl_found, tbl_opErr;
    logic [15:0] tbl_result;
    logic [3:0]  fifo_count;
    logic [1:0]  fsm_state;
`ifdef SEARCH_CMDQ_STATS_EN
    logic [15:0] stat_lookups, stat_hits, stat_errs;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int req_pulses = 0;
    int opreq_pulses = 0;
    int rsp_seen = 0;
    int push_stalls = 0;
    logic op_err_force = 1'b0;

    // {isOp, found, err, result}
    logic [18:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- table model ----------------
    function automatic logic model_found(input logic [47:0] k);
        return (k[7:0] == 8'hAA) || k[1];
    endfunction

    function automatic logic [15:0] model_result(input logic [47:0] k);
        return (k[7:0] == 8'hAA) ? 16'h1234 : (k[15:0] + 16'h0100);
    endfunction

    assign tbl_found  = model_found(tbl_search);
    assign tbl_result = model_result(tbl_search);
    assign tbl_opErr  = op_err_force | tbl_opSearch[3];

    function automatic logic [18:0] exp_rsp(input logic op, input logic [47:0] k);
        logic f;
        f = model_found(k);
        if (op) return {1'b1, 1'b0, op_err_force | k[3], 16'h0000};
        return {1'b0, f, 1'b0, f ? model_result(k) : 16'h0000};
    endfunction

    search_table_cmd_queue #(.DEPTH(DEPTH), .LOOKUP_LAT(2), .OP_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_isOp(cmd_isOp),
        .cmd_opCode(cmd_opCode), .cmd_key(cmd_key), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_isOp(rsp_isOp),
        .rsp_found(rsp_found), .rsp_err(rsp_err), .rsp_result(rsp_result),
        .tbl_req(tbl_req), .tbl_opReq(tbl_opReq), .tbl_search(tbl_search),
        .tbl_opSearch(tbl_opSearch), .tbl_opCode(tbl_opCode),
        .tbl_opResult(tbl_opResult), .tbl_rdy(tbl_rdy), .tbl_opRdy(tbl_opRdy),
        .tbl_found(tbl_found), .tbl_opErr(tbl_opErr), .tbl_result(tbl_result),
        .fifo_count(fifo_count),
`ifdef SEARCH_CMDQ_STATS_EN
        .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_errs(stat_errs),
`endif
        .fsm_state(fsm_state)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic op, input logic [1:0] code,
                            input logic [47:0] k, input logic [15:0] d);
        int waited;
        waited = 0;
        cmd_valid  = 1'b1;
        cmd_isOp   = op;
        cmd_opCode = code;
        cmd_key    = k;
        cmd_data   = d;
        while (!cmd_ready && waited < 300) begin
            tick();
            waited++;
            push_stalls++;
        end
        check("push_accept", cmd_ready, 1'b1);
        if (cmd_ready) begin
            exp_q.push_back(exp_rsp(op, k));
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        logic done;
        rsp_ready = 1'b1;
        i = 0;
        done = 1'b0;
        while (!done && i < budget) begin
            tick();
            i++;
            done = (exp_q.size() == 0) && (fsm_state == 2'd0) && (fifo_count == 4'd0);
        end
        check("drain_done", done, 1'b1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (tbl_req)   req_pulses++;
            if (tbl_opReq) opreq_pulses++;
            check("req_exclusive", tbl_req & tbl_opReq, 1'b0);
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    check("rsp_fields", {rsp_isOp, rsp_found, rsp_err, rsp_result},
                          exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen0;
        int pulses0;
        logic [47:0] k;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_isOp   = 1'b0;
        cmd_opCode = 2'b00;
        cmd_key    = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        tbl_rdy    = 1'b1;
        tbl_opRdy  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_fifo_count", fifo_count, 4'd0);
        check("rst_rsp", {rsp_valid, rsp_isOp, rsp_found, rsp_err, rsp_result}, '0);
        check("rst_strobes", {tbl_req, tbl_opReq}, 2'b00);
        check("rst_tbl_fields", {tbl_search, tbl_opSearch, tbl_opCode, tbl_opResult}, '0);
        check("rst_state", fsm_state, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Lookup with exact cycle timing
        req_pulses = 0;
        opreq_pulses = 0;
        push_cmd(1'b0, 2'b00, 48'h0000_0000_00AA, 16'h0000);   // E0
        check("lk_e0_count", fifo_count, 4'd1);
        check("lk_e0_req", tbl_req, 1'b0);
        tick();                                                // E1
        check("lk_e1_state", fsm_state, 2'd1);
        check("lk_e1_req", tbl_req, 1'b1);
        check("lk_e1_key", tbl_search, 48'h0000_0000_00AA);
        check("lk_e1_count", fifo_count, 4'd0);
        tick();                                                // E2
        check("lk_e2_req", tbl_req, 1'b0);
        check("lk_e2_state", fsm_state, 2'd2);
        tick();                                                // E3
        check("lk_e3_valid", rsp_valid, 1'b0);
        tick();                                                // E4
        check("lk_e4_valid", rsp_valid, 1'b1);
        check("lk_e4_fields", {rsp_found, rsp_err, rsp_result}, {1'b1, 1'b0, 16'h1234});
        rsp_ready = 1'b1;
        tick();
        check("lk_e5_valid", rsp_valid, 1'b0);
        check("lk_req_pulses", req_pulses, 1);
        check("lk_opreq_pulses", opreq_pulses, 0);

        // Add, then the same add failing
        req_pulses = 0;
        opreq_pulses = 0;
        push_cmd(1'b1, 2'b00, 48'h10, 16'h0055);
        drain(40);
        check("add_opresult", tbl_opResult, 16'h0055);
        check("add_keys", {tbl_search, tbl_opSearch}, {48'h10, 48'h10});
        op_err_force = 1'b1;
        push_cmd(1'b1, 2'b00, 48'h10, 16'h0055);
        drain(40);
        op_err_force = 1'b0;
        check("add_opreq_pulses", opreq_pulses, 2);
        check("add_req_pulses", req_pulses, 0);

        // Table not ready: command stays queued
        tbl_rdy = 1'b0;
        push_cmd(1'b0, 2'b00, 48'h04, 16'h0);
        repeat (5) tick();
        check("notrdy_count", fifo_count, 4'd1);
        check("notrdy_state", fsm_state, 2'd0);
        tbl_rdy = 1'b1;
        drain(40);

        // Idle with empty FIFO: no table activity
        pulses0 = req_pulses + opreq_pulses;
        repeat (6) tick();
        check("idle_quiet", req_pulses + opreq_pulses, pulses0);

        // Fill: 9 back-to-back pushes, response held
        rsp_ready = 1'b0;
        req_pulses = 0;
        opreq_pulses = 0;
        push_stalls = 0;
        for (int i = 0; i < 9; i++) begin
            k = {$urandom(), $urandom()};
            push_cmd((i % 3) == 2, 2'(i % 4), k, 16'($urandom_range(0, 65535)));
        end
        check("fill_stalls", push_stalls, 0);
        check("fill_ready", cmd_ready, 1'b0);
        check("fill_count", fifo_count, 4'd8);
        // Full FIFO ignores the tenth command while the response is held
        cmd_valid  = 1'b1;
        cmd_isOp   = 1'b1;
        cmd_opCode = 2'b11;
        cmd_key    = 48'h0000_0000_0F00;
        cmd_data   = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_fields", {rsp_isOp, rsp_found, rsp_err, rsp_result}, exp_q[0]);
            check("hold_count", fifo_count, 4'd8);
        end
        check("hold_one_request", req_pulses + opreq_pulses, 1);
        rsp_ready = 1'b1;
        push_cmd(1'b1, 2'b11, 48'h0000_0000_0F00, 16'hBEEF);
        check("tenth_after_accept", push_stalls > 0, 1'b1);
        drain(200);
        check("fill_total_reqs", req_pulses + opreq_pulses, 10);

        // Reset during WAIT with three commands queued
        push_cmd(1'b1, 2'b01, 48'h20, 16'h0);
        push_cmd(1'b0, 2'b00, 48'h0000_0000_00AA, 16'h0);
        push_cmd(1'b0, 2'b00, 48'h02, 16'h0);
        push_cmd(1'b0, 2'b00, 48'h01, 16'h0);
        check("pre_rst_state", fsm_state, 2'd2);
        check("pre_rst_count", fifo_count, 4'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_strobes", {tbl_req, tbl_opReq}, 2'b00);
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_count", fifo_count, 4'd0);
        check("mid_rst_state", fsm_state, 2'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen0 = rsp_seen;
        pulses0 = req_pulses + opreq_pulses;
        repeat (15) tick();
        check("post_rst_no_rsp", rsp_seen, seen0);
        check("post_rst_no_req", req_pulses + opreq_pulses, pulses0);
        check("post_rst_count", fifo_count, 4'd0);
        check("post_rst_ready", cmd_ready, 1'b1);

        // Statistics workload: 3 lookups (2 hits), 1 failed op
`ifdef SEARCH_CMDQ_STATS_EN
        check("stat_rst", {stat_lookups, stat_hits, stat_errs}, 48'h0);
`endif
        push_cmd(1'b0, 2'b00, 48'h0000_0000_00AA, 16'h0);
        push_cmd(1'b0, 2'b00, 48'h02, 16'h0);
        push_cmd(1'b0, 2'b00, 48'h01, 16'h0);
        drain(100);
        op_err_force = 1'b1;
        push_cmd(1'b1, 2'b01, 48'h30, 16'h0);
        drain(40);
        op_err_force = 1'b0;
`ifdef SEARCH_CMDQ_STATS_EN
        check("stat_lookups", stat_lookups, 16'd3);
        check("stat_hits", stat_hits, 16'd2);
        check("stat_errs", stat_errs, 16'd1);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
